// File: rtl/cic_decimating_comb.sv
// Decimate-by-R and N-stage pipelined comb (differential delay M) of a CIC decimator.
// Optional macro CIC_COMB_ROUND_EN: round-half-up with positive saturation instead of truncation.
module cic_decimating_comb #(
  parameter int W_IN  = 24,
  parameter int W_OUT = 12,
  parameter int R     = 8,
  parameter int N     = 3,
  parameter int M     = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W_IN-1:0]  x,
  input  logic             x_valid,
  output logic [W_OUT-1:0] y,
  output logic             y_valid
);

  localparam int DCW = (R > 1) ? $clog2(R) : 1;
  localparam int NM  = N * M;
  localparam int WCW = $clog2(NM + 1);
  localparam logic [DCW-1:0] DC_LAST = DCW'(R - 1);
  localparam logic [WCW-1:0] WC_SAT  = WCW'(NM);

  logic [DCW-1:0]   dcnt_q, dcnt_d;
  logic [W_IN-1:0]  d_q, d_d;
  // v[0] marks the capture, v[k] a fresh c_k, v[N+1] a fresh scaled value
  logic [N+1:0]     v_q, v_d;
  logic [W_IN-1:0]  c_q [N];
  logic [W_IN-1:0]  c_d [N];
  logic [W_IN-1:0]  z_q [N][M];
  logic [W_IN-1:0]  z_d [N][M];
  logic [W_IN-1:0]  in_w [N];
  logic [W_OUT-1:0] s_q, s_d;
  logic [WCW-1:0]   wcnt_q, wcnt_d;
  logic [W_OUT-1:0] y_q, y_d;
  logic             y_valid_q, y_valid_d;
  logic [W_OUT-1:0] scaled;

  always_comb begin
    in_w[0] = d_q;
    for (int k = 1; k < N; k++) in_w[k] = c_q[k-1];
  end

`ifdef CIC_COMB_ROUND_EN
  if (W_IN > W_OUT) begin : g_round
    localparam logic [W_IN-1:0]  HALF    = W_IN'(1) << (W_IN - W_OUT - 1);
    localparam logic [W_OUT-1:0] SAT_MAX = W_OUT'((64'd1 << (W_OUT - 1)) - 64'd1);
    logic [W_IN-1:0] sum;
    logic            ovf;
    assign sum    = c_q[N-1] + HALF;
    // only a non-negative value can roll over into the sign bit
    assign ovf    = ~c_q[N-1][W_IN-1] & sum[W_IN-1];
    assign scaled = ovf ? SAT_MAX : sum[W_IN-1 -: W_OUT];
  end else begin : g_trunc
    assign scaled = c_q[N-1][W_IN-1 -: W_OUT];
  end
`else
  assign scaled = c_q[N-1][W_IN-1 -: W_OUT];
`endif

  always_comb begin
    dcnt_d    = dcnt_q;
    d_d       = d_q;
    v_d       = '0;
    c_d       = c_q;
    z_d       = z_q;
    s_d       = s_q;
    wcnt_d    = wcnt_q;
    y_d       = y_q;
    y_valid_d = 1'b0;

    if (x_valid) begin
      if (dcnt_q == DC_LAST) begin
        dcnt_d = '0;
        d_d    = x;
        v_d[0] = 1'b1;
      end else begin
        dcnt_d = dcnt_q + 1'b1;
      end
    end

    for (int k = 0; k < N; k++) begin
      if (v_q[k]) begin
        c_d[k]    = in_w[k] - z_q[k][M-1];
        z_d[k][0] = in_w[k];
        for (int i = 1; i < M; i++) z_d[k][i] = z_q[k][i-1];
        v_d[k+1]  = 1'b1;
      end
    end

    if (v_q[N]) begin
      s_d      = scaled;
      v_d[N+1] = 1'b1;
    end

    // warm-up: the first N*M decimated samples update y but raise no strobe
    if (v_q[N+1]) begin
      y_d = s_q;
      if (wcnt_q == WC_SAT) y_valid_d = 1'b1;
      else                  wcnt_d    = wcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dcnt_q    <= '0;
      d_q       <= '0;
      v_q       <= '0;
      s_q       <= '0;
      wcnt_q    <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      for (int k = 0; k < N; k++) begin
        c_q[k] <= '0;
        for (int i = 0; i < M; i++) z_q[k][i] <= '0;
      end
    end else begin
      dcnt_q    <= dcnt_d;
      d_q       <= d_d;
      v_q       <= v_d;
      s_q       <= s_d;
      wcnt_q    <= wcnt_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      for (int k = 0; k < N; k++) begin
        c_q[k] <= c_d[k];
        for (int i = 0; i < M; i++) z_q[k][i] <= z_d[k][i];
      end
    end
  end

  assign y       = y_q;
  assign y_valid = y_valid_q;

endmodule

// File: tb/tb_cic_decimating_comb.sv
// Bench for cic_decimating_comb: three configurations driven in parallel and checked
// against an N-th order lag-M difference model of the decimated stream.
module tb_cic_decimating_comb;

  localparam int R_P [3] = '{8, 8, 1};
  localparam int N_P [3] = '{3, 1, 2};
  localparam int M_P [3] = '{1, 1, 2};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        x_valid = 1'b0;
  logic [23:0] x = '0;
  logic [11:0] y_a, y_b, y_c;
  logic        yv_a, yv_b, yv_c;
  int          edge_cnt = 0;

  int n_checks = 0;
  int n_fail = 0;

  // scoreboard entries are {expected edge index, expected y}
  logic [43:0] exp_q0[$];
  logic [43:0] exp_q1[$];
  logic [43:0] exp_q2[$];

  int          vcnt [3];
  int          ncap [3];
  int          n_out [3];
  logic [23:0] hist [3][16];
  bit          const_en [3];
  logic [11:0] const_v [3];

  cic_decimating_comb #(.W_IN(24), .W_OUT(12), .R(8), .N(3), .M(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .x(x), .x_valid(x_valid), .y(y_a), .y_valid(yv_a));
  cic_decimating_comb #(.W_IN(24), .W_OUT(12), .R(8), .N(1), .M(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .x(x), .x_valid(x_valid), .y(y_b), .y_valid(yv_b));
  cic_decimating_comb #(.W_IN(24), .W_OUT(12), .R(1), .N(2), .M(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .x(x), .x_valid(x_valid), .y(y_c), .y_valid(yv_c));

  // clock / edge counter
  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at edge %0d", tag, obs, exp, edge_cnt);
    end
  endtask

  function automatic logic [11:0] scale(input logic [23:0] f);
    logic [23:0] s;
`ifdef CIC_COMB_ROUND_EN
    s = f + 24'h000800;
    if (!f[23] && s[23]) return 12'h7FF;
    return s[23:12];
`else
    s = f;
    return s[23:12];
`endif
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      vcnt[k] = 0;
      ncap[k] = 0;
    end
    exp_q0.delete();
    exp_q1.delete();
    exp_q2.delete();
  endtask

  // output n = sum_j (-1)^j C(N,j) d[n - j*M], modulo 2^24, once n >= N*M
  task automatic model_capture(input int k, input logic [23:0] dv, input int e);
    longint      acc;
    longint      bin;
    logic [23:0] full;
    logic [43:0] ev;
    hist[k][ncap[k] % 16] = dv;
    if (ncap[k] >= N_P[k] * M_P[k]) begin
      acc = 0;
      bin = 1;
      for (int j = 0; j <= N_P[k]; j++) begin
        if (j % 2 == 1) acc = acc - bin * longint'(hist[k][(ncap[k] - j * M_P[k]) % 16]);
        else            acc = acc + bin * longint'(hist[k][(ncap[k] - j * M_P[k]) % 16]);
        bin = bin * (N_P[k] - j) / (j + 1);
      end
      full = acc[23:0];
      ev = {32'(e + N_P[k] + 2), scale(full)};
      case (k)
        0: exp_q0.push_back(ev);
        1: exp_q1.push_back(ev);
        default: exp_q2.push_back(ev);
      endcase
    end
    ncap[k]++;
  endtask

  task automatic mon(input int k, input logic yv, input logic [11:0] yy);
    logic [43:0] ev;
    bit          have;
    have = 0;
    ev = '0;
    if (yv) begin
      n_out[k]++;
      case (k)
        0: if (exp_q0.size() > 0) begin ev = exp_q0.pop_front(); have = 1; end
        1: if (exp_q1.size() > 0) begin ev = exp_q1.pop_front(); have = 1; end
        default: if (exp_q2.size() > 0) begin ev = exp_q2.pop_front(); have = 1; end
      endcase
      if (!have) begin
        check($sformatf("unexpected_yvalid_%0d", k), 32'(yv), 32'd0);
      end else begin
        check($sformatf("y_value_%0d", k), 32'(yy), 32'(ev[11:0]));
        check($sformatf("y_latency_%0d", k), 32'(edge_cnt), ev[43:12]);
      end
      if (const_en[k]) check($sformatf("y_directed_%0d", k), 32'(yy), 32'(const_v[k]));
    end
  endtask

  // driver: apply inputs for one edge, then observe and update the model
  task automatic step(input logic rst, input logic xv, input logic [23:0] xin);
    rst_n = rst;
    x_valid = xv;
    x = xin;
    @(posedge clk);
    #1;
    if (!rst) begin
      model_reset();
      check("rst_y_a", 32'(y_a), 32'd0);
      check("rst_yv_a", 32'(yv_a), 32'd0);
      check("rst_y_b", 32'(y_b), 32'd0);
      check("rst_yv_b", 32'(yv_b), 32'd0);
      check("rst_y_c", 32'(y_c), 32'd0);
      check("rst_yv_c", 32'(yv_c), 32'd0);
    end else begin
      mon(0, yv_a, y_a);
      mon(1, yv_b, y_b);
      mon(2, yv_c, y_c);
      if (xv) begin
        for (int k = 0; k < 3; k++) begin
          if (vcnt[k] == R_P[k] - 1) begin
            model_capture(k, xin, edge_cnt);
            vcnt[k] = 0;
          end else begin
            vcnt[k]++;
          end
        end
      end
    end
  endtask

  task automatic ramp(input logic [23:0] start, input logic [23:0] inc, input logic [11:0] b_exp);
    logic [23:0] xr;
    xr = start;
    step(1'b0, 1'b1, 24'h0);
    step(1'b0, 1'b0, 24'h0);
    const_en[1] = 1;
    const_v[1] = b_exp;
    for (int i = 0; i < 220; i++) begin
      if ((i >= 37 && i < 42) || (i >= 150 && i < 155)) begin
        step(1'b1, 1'b0, $urandom);
      end else begin
        step(1'b1, 1'b1, xr);
        xr = xr + inc;
      end
    end
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, xr);
    const_en[1] = 0;
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      n_out[k] = 0;
      const_en[k] = 0;
      const_v[k] = '0;
    end
    model_reset();

    // reset held with activity on the inputs
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 24'h123456);

    // DC input, then a one-cycle reset mid-frame after 20 decimated samples
    const_en[0] = 1;
    const_v[0] = 12'h000;
    for (int i = 0; i < 164; i++) step(1'b1, 1'b1, 24'h000100);
    step(1'b0, 1'b1, 24'h000100);
    for (int i = 0; i < 80; i++) step(1'b1, 1'b1, 24'h000100);
    const_en[0] = 0;

    // ramps on the N=1 instance, including a wrap through 0x7FFFFF and input gaps
    ramp(24'h7E0000, 24'h001000, 12'h008);
`ifdef CIC_COMB_ROUND_EN
    ramp(24'h000000, 24'h000900, 12'h005);
`else
    ramp(24'h000000, 24'h000900, 12'h004);
`endif
    ramp(24'h000000, 24'h0FFF00, 12'h7FF);

    // randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 249) != 0), ($urandom_range(0, 3) != 0), 24'($urandom));
    end

    // drain everything in flight
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 24'h0);

    check("drain_q_a", 32'(exp_q0.size()), 32'd0);
    check("drain_q_b", 32'(exp_q1.size()), 32'd0);
    check("drain_q_c", 32'(exp_q2.size()), 32'd0);
    check("outputs_seen_a", 32'(n_out[0] > 100), 32'd1);
    check("outputs_seen_b", 32'(n_out[1] > 100), 32'd1);
    check("outputs_seen_c", 32'(n_out[2] > 1000), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
